// File: rtl/depkt_pkg.sv
// Shared packet field layout and FSM state type for the node depacketizers.
package depkt_pkg;

  localparam int TYPE_BIT = 46;
  localparam int DEST_MSB = 45;
  localparam int DEST_LSB = 43;
  localparam int SRC_MSB  = 42;
  localparam int SRC_LSB  = 40;
  localparam int DATA_MSB = 7;
  localparam int DATA_LSB = 0;

  localparam int   ADDR_W    = 3;
  localparam logic PSUM_TYPE = 1'b1;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} depkt_state_t;

endpackage

// File: rtl/pkt_hdr_decode.sv
// Splits a router packet into type/dest/src/data fields.
// With DEPKT_DEST_CHECK_EN defined it also flags packets addressed to this node.
module pkt_hdr_decode
  import depkt_pkg::*;
#(
  parameter int PWIDTH = 47,
  parameter int DWIDTH = 8
`ifdef DEPKT_DEST_CHECK_EN
  ,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 3'b110
`endif
) (
  input  logic [PWIDTH-1:0] in_packet,
  output logic              pkt_type,
  output logic [ADDR_W-1:0] dest,
  output logic [ADDR_W-1:0] src,
  output logic [DWIDTH-1:0] data
`ifdef DEPKT_DEST_CHECK_EN
  ,
  output logic              hdr_ok
`endif
);

  logic unused_pad;

  assign pkt_type = in_packet[TYPE_BIT];
  assign dest     = in_packet[DEST_MSB:DEST_LSB];
  assign src      = in_packet[SRC_MSB:SRC_LSB];
  assign data     = in_packet[DATA_LSB +: DWIDTH];

  // Pad bits carry nothing for this node.
  assign unused_pad = ^in_packet[SRC_LSB-1:DATA_LSB+DWIDTH];

`ifdef DEPKT_DEST_CHECK_EN
  assign hdr_ok = (pkt_type == PSUM_TYPE) && (dest == NODE_ADDR);
`endif

endmodule

// File: rtl/depkt_adder.sv
// Adder-node depacketizer: gathers NUM_OPS partial sums into one operand bundle.
// Optional header filtering and drop counting under DEPKT_DEST_CHECK_EN.
//
// state   | meaning
// COLLECT | accepting packets, filling slot cnt
// HOLD    | bundle presented to adder, input stalled
module depkt_adder
  import depkt_pkg::*;
#(
  parameter int                DWIDTH    = 8,
  parameter int                PWIDTH    = 47,
  parameter logic [ADDR_W-1:0] NODE_ADDR = 3'b110,
  parameter int                NUM_OPS   = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PWIDTH-1:0]           in_packet,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_OPS*DWIDTH-1:0]   out_ops,
  output logic [NUM_OPS*ADDR_W-1:0]   out_src
`ifdef DEPKT_DEST_CHECK_EN
  ,
  output logic                        drop_pulse,
  output logic [7:0]                  drop_count
`endif
);

  localparam int CW = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam logic [0:0] S_COLLECT = COLLECT;
  localparam logic [0:0] S_HOLD    = HOLD;

  logic [0:0]        state;
  logic [CW-1:0]     cnt;
  logic              pkt_type;
  logic [ADDR_W-1:0] dest;
  logic [ADDR_W-1:0] src;
  logic [DWIDTH-1:0] data;
  logic              hdr_ok;
  logic              xfer;

`ifdef DEPKT_DEST_CHECK_EN
  pkt_hdr_decode #(
    .PWIDTH    (PWIDTH),
    .DWIDTH    (DWIDTH),
    .NODE_ADDR (NODE_ADDR)
  ) u_hdr (
    .in_packet (in_packet),
    .pkt_type  (pkt_type),
    .dest      (dest),
    .src       (src),
    .data      (data),
    .hdr_ok    (hdr_ok)
  );
`else
  logic unused_hdr;

  pkt_hdr_decode #(
    .PWIDTH    (PWIDTH),
    .DWIDTH    (DWIDTH)
  ) u_hdr (
    .in_packet (in_packet),
    .pkt_type  (pkt_type),
    .dest      (dest),
    .src       (src),
    .data      (data)
  );

  assign hdr_ok     = 1'b1;
  assign unused_hdr = ^{pkt_type, dest, NODE_ADDR};
`endif

  // Ready comes from state only; reset masks it so nothing is taken while held.
  assign in_ready  = (state == S_COLLECT) && !reset;
  assign out_valid = (state == S_HOLD);
  assign xfer      = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_COLLECT;
      cnt     <= '0;
      out_ops <= '0;
      out_src <= '0;
    end else begin
      case (state)
        S_COLLECT: begin
          if (xfer && hdr_ok) begin
            for (int i = 0; i < NUM_OPS; i++) begin
              if (cnt == CW'(i)) begin
                out_ops[i*DWIDTH +: DWIDTH] <= data;
                out_src[i*ADDR_W +: ADDR_W] <= src;
              end
            end
            if (cnt == CW'(NUM_OPS-1)) begin
              cnt   <= '0;
              state <= S_HOLD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          if (out_ready) state <= S_COLLECT;
        end
      endcase
    end
  end

`ifdef DEPKT_DEST_CHECK_EN
  // Misaddressed or non-psum packets are still consumed so the router never stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_pulse <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      drop_pulse <= xfer && !hdr_ok;
      if (xfer && !hdr_ok && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_depkt_adder.sv
// Directed and randomized-gap bench for depkt_adder (NUM_OPS=3).
module tb_depkt_adder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [46:0] in_packet;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_ops;
  logic [8:0]  out_src;
`ifdef DEPKT_DEST_CHECK_EN
  logic        drop_pulse;
  logic [7:0]  drop_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  depkt_adder dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_packet (in_packet),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ops   (out_ops),
    .out_src   (out_src)
`ifdef DEPKT_DEST_CHECK_EN
    ,
    .drop_pulse(drop_pulse),
    .drop_count(drop_count)
`endif
  );

  function automatic logic [46:0] mk(input logic t, input logic [2:0] d, input logic [2:0] s,
                                     input logic [7:0] v);
    return {t, d, s, 32'hDEAD_BEEF, v};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  // Offer one good packet per cycle; all are expected to be accepted.
  task automatic send(input logic [2:0] s, input logic [7:0] v);
    in_valid  = 1'b1;
    in_packet = mk(1'b1, 3'b110, s, v);
    step();
    in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    in_packet = mk(1'b1, 3'b110, 3'b000, 8'h5A);
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ops !== 24'h0) begin failures++; $display("FAIL reset_ops got=%h exp=000000", out_ops); end
    checks++; if (out_src !== 9'h0) begin failures++; $display("FAIL reset_src got=%h exp=000", out_src); end
`ifdef DEPKT_DEST_CHECK_EN
    checks++; if (drop_count !== 8'd0 || drop_pulse !== 1'b0) begin failures++; $display("FAIL reset_drop got=%0d/%b exp=0/0", drop_count, drop_pulse); end
`endif
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", in_ready); end
    step();
  endtask

  task automatic test_basic();
    logic [7:0] d [3] = '{8'h05, 8'h0A, 8'hFF};
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_packet = mk(1'b1, 3'b110, 3'(i), d[i]);
      @(negedge clk);
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_collect%0d ready=%b valid=%b exp 1/0", i, in_ready, out_valid); end
      step();
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL basic_hold valid=%b ready=%b exp 1/0", out_valid, in_ready); end
    checks++; if (out_ops !== 24'hFF0A05) begin failures++; $display("FAIL basic_ops got=%h exp=ff0a05", out_ops); end
    checks++; if (out_src !== 9'b010_001_000) begin failures++; $display("FAIL basic_src got=%b exp=010001000", out_src); end
    step();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL basic_release valid=%b ready=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    send(3'd0, 8'h05);
    send(3'd1, 8'h0A);
    send(3'd2, 8'hFF);
    in_valid  = 1'b1;
    in_packet = mk(1'b1, 3'b110, 3'd3, 8'h44);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL bp_hold%0d valid=%b ready=%b exp 1/0", k, out_valid, in_ready); end
      checks++; if (out_ops !== 24'hFF0A05 || out_src !== 9'b010_001_000) begin failures++; $display("FAIL bp_stable%0d ops=%h src=%b exp ff0a05/010001000", k, out_ops, out_src); end
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_handshake_ready got=%b exp=0", in_ready); end
    step();
    @(negedge clk);
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL bp_return ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    step();
    send(3'd4, 8'h55);
    send(3'd5, 8'h66);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_ops !== 24'h665544 || out_src !== 9'b101_100_011) begin failures++; $display("FAIL bp_next valid=%b ops=%h src=%b exp 1/665544/101100011", out_valid, out_ops, out_src); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b1;
    send(3'd1, 8'hAA);
    send(3'd2, 8'hBB);
    do_reset();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_ops !== 24'h0) begin failures++; $display("FAIL midreset_clear valid=%b ops=%h exp 0/000000", out_valid, out_ops); end
    send(3'd3, 8'h11);
    send(3'd4, 8'h22);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset_early valid=%b exp=0", out_valid); end
    send(3'd5, 8'h33);
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_ops !== 24'h332211 || out_src !== 9'b101_100_011) begin failures++; $display("FAIL midreset_bundle valid=%b ops=%h src=%b exp 1/332211/101100011", out_valid, out_ops, out_src); end
    step();
  endtask

`ifdef DEPKT_DEST_CHECK_EN
  task automatic test_dest_check();
    logic [46:0] seq [5];
    logic        bad [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int          pulses = 0;
    seq[0] = mk(1'b1, 3'b110, 3'd0, 8'h05);
    seq[1] = mk(1'b1, 3'b101, 3'd7, 8'h77);
    seq[2] = mk(1'b1, 3'b110, 3'd1, 8'h0A);
    seq[3] = mk(1'b0, 3'b110, 3'd6, 8'h88);
    seq[4] = mk(1'b1, 3'b110, 3'd2, 8'hFF);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_packet = seq[i];
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL dc_ready%0d got=%b exp=1", i, in_ready); end
      step();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (drop_pulse !== bad[i]) begin failures++; $display("FAIL dc_pulse%0d got=%b exp=%b", i, drop_pulse, bad[i]); end
      if (drop_pulse === 1'b1) pulses++;
      if (i < 4) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dc_early%0d valid=%b exp=0", i, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1 || out_ops !== 24'hFF0A05 || out_src !== 9'b010_001_000) begin failures++; $display("FAIL dc_bundle valid=%b ops=%h src=%b exp 1/ff0a05/010001000", out_valid, out_ops, out_src); end
    checks++; if (drop_count !== 8'd2 || pulses != 2) begin failures++; $display("FAIL dc_count count=%0d pulses=%0d exp 2/2", drop_count, pulses); end
    step();
    in_valid  = 1'b1;
    in_packet = mk(1'b1, 3'b011, 3'd0, 8'h01);
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (drop_count !== 8'd255) begin failures++; $display("FAIL dc_saturate got=%0d exp=255", drop_count); end
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL dc_flood_state ready=%b valid=%b exp 1/0", in_ready, out_valid); end
    step();
  endtask
`endif

  task automatic test_random();
    logic [7:0] qd [$];
    logic [2:0] qs [$];
    logic [23:0] eops;
    logic [8:0]  esrc;
    int sent = 0;
    int delivered = 0;
    int cyc = 0;
    logic [7:0] nd = 8'h00;
    logic [2:0] ns = 3'd0;
    do_reset();
    while ((sent < 1002 || qd.size() != 0) && cyc < 20000) begin
      in_valid  = (sent < 1002) && ($urandom_range(0, 3) != 0);
      in_packet = mk(1'b1, 3'b110, ns, nd);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        qd.push_back(nd);
        qs.push_back(ns);
        sent++;
        nd = nd + 8'd37;
        ns = ns + 3'd3;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (qd.size() < 3) begin
          failures++;
          $display("FAIL rnd_underflow bundle=%0d queued=%0d exp>=3", delivered, qd.size());
        end else begin
          eops = {qd[2], qd[1], qd[0]};
          esrc = {qs[2], qs[1], qs[0]};
          for (int k = 0; k < 3; k++) begin
            void'(qd.pop_front());
            void'(qs.pop_front());
          end
          if (out_ops !== eops || out_src !== esrc) begin
            failures++;
            $display("FAIL rnd_bundle%0d ops=%h src=%b exp %h/%b", delivered, out_ops, out_src, eops, esrc);
          end
        end
        delivered++;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (cyc >= 20000) begin failures++; $display("FAIL rnd_timeout sent=%0d delivered=%0d exp 1002/334", sent, delivered); end
    checks++; if (delivered != 334 || qd.size() != 0) begin failures++; $display("FAIL rnd_total delivered=%0d left=%0d exp 334/0", delivered, qd.size()); end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    in_packet = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid();
`ifdef DEPKT_DEST_CHECK_EN
    test_dest_check();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/depkt_adder.md
# depkt_adder

Clocked depacketizer for the adder node: the receive end of the 47-bit packet format that the adder packetizer emits. It accepts packets from the router side and checks the header. It collects `NUM_OPS` 8-bit partial sums into one operand bundle, then presents the bundle to the adder core with a valid/ready handshake. It sits between the router's output port toward node address 3'b110 and the adder's operand input.

## Interface
- `DWIDTH`, default 8: partial-sum data width.
- `PWIDTH`, default 47: packet width.
- `NODE_ADDR`, default 3'b110: this node's address.
- `NUM_OPS`, default 3: partial sums per bundle; must be ≥ 1.
- `clk`  in  1  — single clock, all logic on rising edge.
- `reset`  in  1  — synchronous, active-high.
- `in_valid`  in  1  — packet offered.
- `in_ready`  out  1  — depacketizer can accept.
- `in_packet`  in  PWIDTH  — packet fields:
  - [46] type (1 = psum)
  - [45:43] destination
  - [42:40] source
  - [39:8] pad, ignored
  - [7:0] data
- `out_valid`  out  1  — bundle available.
- `out_ready`  in  1  — adder consumes bundle.
- `out_ops`  out  NUM_OPS*DWIDTH  — slot i at [i*DWIDTH +: DWIDTH], in arrival order.
- `out_src`  out  NUM_OPS*3  — source address of slot i at [i*3 +: 3].
- `drop_pulse`  out  1  — one-cycle pulse per dropped packet; present only with `DEPKT_DEST_CHECK_EN`.
- `drop_count`  out  8  — saturating dropped-packet count; present only with `DEPKT_DEST_CHECK_EN`.

## Operation
- States:
  - COLLECT: `in_ready`=1, `out_valid`=0.
  - HOLD: `in_ready`=0, `out_valid`=1.
- `in_ready` is decoded from registered state only. It never depends on `in_valid` or `out_ready`.
- Transfer occurs on a rising edge with `in_valid && in_ready`. A transfer of an accepted packet:
  - writes data[7:0] to slot `cnt`;
  - writes src[42:40] to `out_src` slot `cnt`;
  - increments `cnt`.
- Transfer when `cnt == NUM_OPS-1`: write the last slot, clear `cnt` to 0, go to HOLD.
- HOLD → COLLECT on `out_valid && out_ready`. `out_ops`/`out_src` hold stable throughout HOLD.
- The pad field is ignored. Data is passed unsigned with no width change.
- Reset:
  - state=COLLECT, `cnt`=0;
  - `out_valid`=0, `out_ops`=0, `out_src`=0;
  - `drop_pulse`=0, `drop_count`=0;
  - `in_ready`=0 while `reset` is high.
- Reset mid-collection or during HOLD discards the partial or undelivered bundle. No bundle is emitted for it.
- `NUM_OPS`=1: every accepted packet goes straight to HOLD.

## Timing
- Bundle latency: `out_valid` rises on the edge that accepts the final packet, i.e. visible the cycle after that transfer.
- Minimum throughput: NUM_OPS+1 cycles per bundle, because HOLD always costs at least one cycle with `in_ready`=0.
- `out_ready` held high: HOLD lasts exactly one cycle and `in_ready` returns the next cycle.
- `out_ready` low: HOLD persists indefinitely. Backpressure reaches the router because `in_ready` stays 0.
- `drop_pulse` is registered: high for the one cycle after the dropping transfer.

## Configuration
- `DEPKT_DEST_CHECK_EN` defined:
  - A transfer whose dest ≠ `NODE_ADDR` or whose type ≠ 1 is still handshaken (consumed), so the router never stalls.
  - Such a packet does not write a slot and does not advance `cnt`.
  - It pulses `drop_pulse` and increments `drop_count`, which saturates at 255.
- `DEPKT_DEST_CHECK_EN` undefined:
  - Every transfer is accepted regardless of header.
  - `drop_pulse`/`drop_count` ports and logic are absent.

## Structure
- Package `depkt_pkg` holds:
  - field bit positions: `TYPE_BIT`=46, `DEST_MSB`/`LSB`=45/43, `SRC_MSB`/`LSB`=42/40, `DATA_MSB`/`LSB`=7/0;
  - `ADDR_W`=3 and `PSUM_TYPE`=1'b1;
  - `typedef enum logic {COLLECT, HOLD} depkt_state_t`.
- One combinational sub-module, `pkt_hdr_decode`: splits `in_packet` into type/dest/src/data. Under the macro it also produces `hdr_ok`. It is reused by other node depacketizers.
- Top level holds the FSM, `cnt`, slot registers and the drop counter.

## Test plan
- Reset, then 3 packets {1,110,000,…,0x05}, {1,110,001,…,0x0A}, {1,110,010,…,0xFF} on consecutive cycles with `out_ready`=1 → `out_ops`={0xFF,0x0A,0x05}, `out_src`={010,001,000}. `out_valid` is high for exactly 1 cycle, and `in_ready` is 0 only in that cycle.
- Same bundle with `out_ready`=0 for 5 cycles → `out_valid` and data stable for 5 cycles, `in_ready`=0 throughout. The 4th offered packet is accepted only after the `out_ready` handshake.
- `DEPKT_DEST_CHECK_EN`: interleave packets with dest=101 and with type=0 among 3 valid packets → both bad packets consumed. The bundle contains only the 3 valid data values, `drop_pulse` fires twice and `drop_count`=2. Force 300 bad packets → `drop_count`=255.
- Assert `reset` after 2 of 3 packets are accepted, then send 3 fresh packets 0x11/0x22/0x33 → the bundle is exactly {0x33,0x22,0x11}, with no stale data.
- Random `in_valid`/`out_ready` gaps over 1000 packets → the scoreboard shows every accepted psum delivered once, in order, with no bundle lost or duplicated.
